// File: rtl/printing_pkg.sv
// Shared constants and the decoder state type for the alpha tag decoder.
// Included by alpha_char_classify and alpha_id_decoder.
package printing_pkg;

  localparam int ALPHA_BASE          = 26;
  localparam int ALPHA_SINGLE_OFFSET = 676;
  localparam int ALPHA_ID_MAX        = 701;

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_TAB   = 8'h09;
  localparam logic [7:0] CH_NUL   = 8'h00;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2,
    S_DRAIN = 2'd3
  } alpha_dec_state_t;

endpackage

// File: rtl/alpha_char_classify.sv
// Combinational byte classifier: letter / delimiter / illegal, plus letter value.
// Uppercase bytes count as letters only when ALPHA_ID_DEC_UPPER_EN is defined.
module alpha_char_classify
  import printing_pkg::*;
(
  input  logic [7:0] data,
  output logic       is_letter,
  output logic       is_delim,
  output logic [4:0] value
);

  logic [7:0] lower_off;
  logic [7:0] upper_off;

  assign lower_off = data - 8'h61;
  assign upper_off = data - 8'h41;

  always_comb begin
    is_letter = 1'b0;
    value     = 5'd0;
    if (data >= 8'h61 && data <= 8'h7A) begin
      is_letter = 1'b1;
      value     = lower_off[4:0];
    end
`ifdef ALPHA_ID_DEC_UPPER_EN
    else if (data >= 8'h41 && data <= 8'h5A) begin
      is_letter = 1'b1;
      value     = upper_off[4:0];
    end
`endif
  end

  always_comb begin
    is_delim = 1'b0;
    if (data == CH_SPACE || data == CH_LF || data == CH_TAB || data == CH_NUL)
      is_delim = 1'b1;
  end

`ifndef ALPHA_ID_DEC_UPPER_EN
  logic unused_upper;
  assign unused_upper = ^upper_off;
`endif

endmodule

// File: rtl/alpha_id_decoder.sv
// Streaming decoder from two-letter alpha tags to integer IDs with a single-entry
// output register. Optional uppercase letters via ALPHA_ID_DEC_UPPER_EN.
//
// Handshakes: a byte transfers on a rising edge where in_valid && in_ready; a
// result transfers where out_valid && out_ready. Neither side may withdraw or
// change its payload while valid is high and ready is low.
module alpha_id_decoder
  import printing_pkg::*;
#(
  parameter int ID_W  = 10,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ID_W-1:0]  out_id,
  output logic             out_err,
  output logic [CNT_W-1:0] tok_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output alpha_dec_state_t state
);

  alpha_dec_state_t state_d;
  logic [4:0]       c1_q, c1_d;
  logic [4:0]       c2_q, c2_d;
  logic             is_letter, is_delim;
  logic [4:0]       value;
  logic             accept;
  logic             emit, emit_err;
  logic [ID_W-1:0]  emit_id;
  logic [ID_W-1:0]  l1, l2, l1_x26;

  alpha_char_classify u_classify (
    .data      (in_data),
    .is_letter (is_letter),
    .is_delim  (is_delim),
    .value     (value)
  );

  assign in_ready = !out_valid;
  assign accept   = in_valid && in_ready;

  assign l1     = {{(ID_W-5){1'b0}}, c1_q};
  assign l2     = {{(ID_W-5){1'b0}}, c2_q};
  // x26 as shift-and-add: 16 + 8 + 2
  assign l1_x26 = (l1 << 4) + (l1 << 3) + (l1 << 1);

  always_comb begin
    state_d  = state;
    c1_d     = c1_q;
    c2_d     = c2_q;
    emit     = 1'b0;
    emit_err = 1'b0;
    emit_id  = '0;
    if (accept) begin
      case (state)
        S_IDLE: begin
          if (is_letter) begin
            state_d = S_ONE;
            c1_d    = value;
          end else if (!is_delim) begin
            state_d = S_DRAIN;
          end
        end
        S_ONE: begin
          if (is_letter) begin
            state_d = S_TWO;
            c2_d    = value;
          end else if (is_delim) begin
            state_d = S_IDLE;
            emit    = 1'b1;
            emit_id = ID_W'(ALPHA_SINGLE_OFFSET) + l1;
          end else begin
            state_d = S_DRAIN;
          end
        end
        S_TWO: begin
          if (is_delim) begin
            state_d = S_IDLE;
            emit    = 1'b1;
            emit_id = l1_x26 + l2;
          end else begin
            state_d = S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (is_delim) begin
            state_d  = S_IDLE;
            emit     = 1'b1;
            emit_err = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      c1_q  <= '0;
      c2_q  <= '0;
    end else begin
      state <= state_d;
      c1_q  <= c1_d;
      c2_q  <= c2_d;
    end
  end

  // Emit and output handshake are mutually exclusive since in_ready = !out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_id    <= '0;
      out_err   <= 1'b0;
      tok_cnt   <= '0;
      err_cnt   <= '0;
    end else if (emit) begin
      out_valid <= 1'b1;
      out_id    <= emit_id;
      out_err   <= emit_err;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
      if (out_err) begin
        if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
      end else begin
        if (tok_cnt != '1) tok_cnt <= tok_cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/alpha_id_decoder.md
# alpha_id_decoder

Streaming decoder that turns the two-letter alphanumeric transaction tags emitted in bench logs and trace streams back into integer transaction IDs. It accepts ASCII bytes over a valid/ready interface, splits them into tokens at delimiters, and emits one decoded ID (or an error) per non-empty token. It sits on the trace-replay path between the byte source (log reader / UART model) and the scoreboard's transaction-ID lookup.

## Interface
- ID_W, 10, output ID width; must be ≥10 (max ID 701)
- CNT_W, 16, width of the saturating statistics counters
- clk  in  1  clock; all logic rising-edge
- rst_n  in  1  reset; asynchronous, active-low
- in_valid  in  1  byte available
- in_data  in  8  ASCII byte
- in_ready  out  1  byte accepted when in_valid && in_ready
- out_valid  out  1  decoded result held
- out_ready  in  1  result consumed when out_valid && out_ready
- out_id  out  ID_W  decoded ID; 0 when out_err
- out_err  out  1  token was illegal or over-long
- tok_cnt  out  CNT_W  tokens emitted without error, saturating
- err_cnt  out  CNT_W  error tokens emitted, saturating

## Operation
- Letter: 'a'..'z' (0x61–0x7A), value L = byte−0x61. Delimiter: 0x20, 0x0A, 0x09, 0x00. Any other byte is illegal.
- Encoding being inverted: two letters c1 c2 → ID = L(c1)·26 + L(c2), range 0..675; single letter c → ID = 676 + L(c), range 676..701.
- FSM states: S_IDLE (no letter held), S_ONE (c1 held), S_TWO (c1,c2 held), S_DRAIN (discard until delimiter).
  - S_IDLE: letter → S_ONE; delimiter → stay, nothing emitted (empty tokens ignored); illegal → S_DRAIN.
  - S_ONE: letter → S_TWO; delimiter → emit 676+L(c1), → S_IDLE; illegal → S_DRAIN.
  - S_TWO: delimiter → emit L(c1)·26+L(c2), → S_IDLE; letter or illegal → S_DRAIN.
  - S_DRAIN: delimiter → emit error (out_err=1, out_id=0), → S_IDLE; any other byte → stay.
- Arithmetic: L(c1)·26 computed as (L<<4)+(L<<3)+(L<<1) in ID_W bits; no overflow possible.
- Output register is single-entry. in_ready = !out_valid.
- tok_cnt increments on each handshake with out_err=0; err_cnt on each with out_err=1; both hold at all-ones.

## Timing
- Reset values: in_ready=1, out_valid=0, out_id=0, out_err=0, tok_cnt=0, err_cnt=0, state S_IDLE.
- Latency: delimiter accepted in cycle N → out_valid=1 in cycle N+1.
- out_valid, out_id, out_err stable until handshake; out_valid falls the cycle after handshake, in_ready rises the same cycle.
- Sustained throughput with out_ready=1: one byte per cycle, except one stall cycle after each emitting delimiter.
- Counters update the cycle after the output handshake.
- Reset asserted mid-token or with out_valid high: partial token and pending result discarded, counters cleared, no output on deassert.

## Configuration
- ALPHA_ID_DEC_UPPER_EN defined: 'A'..'Z' (0x41–0x5A) are letters too, L = byte−0x41; mixed case within a token allowed ("Ab" = 1).
- Not defined: uppercase bytes are illegal and send the token to S_DRAIN.

## Structure
- printing_pkg gains: ALPHA_BASE=26, ALPHA_SINGLE_OFFSET=676, ALPHA_ID_MAX=701, delimiter byte constants, and the state enum typedef alpha_dec_state_t.
- One sub-module: alpha_char_classify (combinational) — byte in, outputs is_letter, is_delim, letter value[4:0]; macro handling lives there only.

## Test plan
- Stream "aa az ba zz\n", out_ready=1 → IDs 0, 25, 26, 675, no errors; tok_cnt=4.
- Stream "a z\n" → IDs 676, 701; "   \n\n" alone → no output.
- Stream "abc a1 b\n" → err, err, ID 677; err_cnt=2, tok_cnt=1; out_id=0 on errors.
- "qq " with out_ready held 0 for 10 cycles → out_valid=1, out_id=432 stable, in_ready=0 throughout; one cycle after out_ready=1, in_ready=1.
- Assert rst_n low after "b" of "bq " → after release, " \n" gives no output; all outputs at reset values.
- "Ab " → ID 1 with ALPHA_ID_DEC_UPPER_EN; error without it.
